seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
Parametrised serial pattern detector. It is the next generation of the fixed 4-bit "1010" Mealy detector.
- Pattern length is a generic parameter; the pattern is programmable at runtime.
- Overlapping and non-overlapping detection are selectable.
- Input bits are qualified by a valid strobe.
- Matches are counted in a saturating counter.
- Sits on the serial receive path and feeds frame-sync and status logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..32).
- DEF_PATTERN, 4'b1010 (width PAT_LEN), pattern loaded at reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when 1.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_load  input  1  one-cycle strobe that loads cfg_pattern.
- cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit received.
- cnt_clr  input  1  synchronous clear of match_cnt.
- y  output  1  one-cycle match pulse (registered).
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt equals all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - hist=0, fill=0, pat_reg=DEF_PATTERN.
  - y=0, match_cnt=0, cnt_sat=0.
  - All are held until reset deasserts.
- Internal state:
  - hist: last PAT_LEN-1 accepted bits.
  - fill: counter 0..PAT_LEN-1, the number of valid history bits. This is the detector state and replaces fixed S0..S3.
- Accepted bit (din_valid=1, cfg_load=0):
  - cand = {hist, din}.
  - hit = (fill == PAT_LEN-1) && (cand == pat_reg).
  - Next edge: y <= hit.
- History update on an accepted bit:
  - hit=0 or overlap_en=1: hist shifts in din and fill increments, saturating at PAT_LEN-1.
  - hit=1 and overlap_en=0: hist <= 0 and fill <= 0. No bit of the matched pattern is reused.
- Latency: y rises on the clock edge that samples the final pattern bit and stays high exactly one cycle. It is deasserted on any cycle where din_valid=0.
- din_valid=0: hist, fill and match_cnt hold; y=0.
- Match counter:
  - On hit, match_cnt increments and saturates at 2^CNT_W-1. cnt_sat = (match_cnt == all-ones), registered with match_cnt.
  - cnt_clr has priority over a same-cycle hit: match_cnt becomes 0. y still pulses for that hit.
- cfg_load:
  - Takes priority over din_valid. On that cycle pat_reg <= cfg_pattern, hist <= 0, fill <= 0, y <= 0.
  - The din of that cycle is discarded. match_cnt is unaffected.
- overlap_en may change at any time; it takes effect on the next accepted bit.
- Reset asserted mid-pattern discards partial history. After release, the full PAT_LEN bits must arrive before any match.
- Empty-history rule: no match is possible until PAT_LEN accepted bits have been seen since reset, cfg_load or a non-overlap match. This holds even when pat_reg is all zeros, because hist=0 must not alias a match.

Test Plan:
- Default 1010, overlap_en=1, din_valid=1, stream 1,0,1,0,1,0 -> y pulses after bits 4 and 6; match_cnt=2.
- Same stream, overlap_en=0 -> y pulses after bit 4 only; stream 1,0,1,0,1,0,1,0 -> pulses after bits 4 and 8; match_cnt=2.
- Stream 1,0,1,0 with din_valid low for 3 cycles between each bit -> single y pulse, aligned to the 4th valid bit; y=0 during gaps.
- cfg_load with cfg_pattern=4'b0000 after bits 1,0 sent, then 0,0,0 -> no match; a 4th 0 -> match; any din on the cfg_load cycle is ignored.
- CNT_W=2, 5 overlapping matches of 1010 -> match_cnt stops at 3, cnt_sat=1; cnt_clr on a hit cycle -> match_cnt=0, y=1.
- reset pulsed low asynchronously after bits 1,0,1 -> y, match_cnt and fill are 0 immediately; next bit 0 gives no match; a fresh 1,0,1,0 then matches.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial detector for a runtime-programmable PAT_LEN-bit pattern with a saturating match count
module seq_pattern_detector #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = PAT_LEN'(4'b1010),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap_en,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] cand;
    logic               hit;
    logic [CNT_W-1:0]   cnt_nxt;

    // fill gates the compare so an all-zero pattern cannot alias the cleared history
    always_comb begin
        cand    = {hist, din};
        hit     = din_valid && !cfg_load && (fill == FULL) && (cand == pat_reg);
        cnt_nxt = cnt_clr ? '0 : (hit && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist      <= '0;
            fill      <= '0;
            pat_reg   <= DEF_PATTERN;
            y         <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_reg <= cfg_pattern;
                hist    <= '0;
                fill    <= '0;
            end else if (din_valid) begin
                hist <= (hit && !overlap_en) ? '0 : cand[PAT_LEN-2:0];
                fill <= (hit && !overlap_en) ? '0 : (fill == FULL) ? fill : fill + 1'b1;
            end
            y         <= hit;
            match_cnt <= cnt_nxt;
            cnt_sat   <= &cnt_nxt;
        end
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench; dut uses CNT_W=8, dut2 uses CNT_W=2 on the same stimulus
module tb_seq_pattern_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       cnt_clr = 1'b0;
    logic       y, y2, cnt_sat, cnt_sat2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic       sb[$];
    logic       exp_y;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap_en(overlap_en),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .y(y2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic step(input logic d, input logic v, input logic ld, input logic [3:0] p,
                        input logic clr, input logic ey);
        din = d; din_valid = v; cfg_load = ld; cfg_pattern = p; cnt_clr = clr;
        sb.push_back(ey);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (y !== 1'b0 || y2 !== 1'b0) $display("FAIL reset_y got %b/%b want 0", y, y2); else passed++;
        checks++; if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) $display("FAIL reset_cnt got %0d/%0d want 0", match_cnt, match_cnt2); else passed++;
        checks++; if (cnt_sat !== 1'b0 || cnt_sat2 !== 1'b0) $display("FAIL reset_sat got %b/%b want 0", cnt_sat, cnt_sat2); else passed++;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap();
        logic [5:0] b = 6'b101010, e = 6'b000101;
        overlap_en = 1'b1;
        step(0, 0, 1, 4'b1010, 1, 0);
        exp_y = sb.pop_front();
        checks++; if (y !== exp_y) $display("FAIL ovl_init_y got %b want %b", y, exp_y); else passed++;
        for (int i = 5; i >= 0; i--) begin
            step(b[i], 1, 0, 4'b0000, 0, e[i]);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y || y2 !== exp_y) $display("FAIL ovl_y bit%0d got %b/%b want %b", 6 - i, y, y2, exp_y); else passed++;
        end
        checks++; if (match_cnt !== 8'd2 || match_cnt2 !== 2'd2) $display("FAIL ovl_cnt got %0d/%0d want 2", match_cnt, match_cnt2); else passed++;
    endtask

    task automatic test_non_overlap();
        logic [7:0] b = 8'b10101010, e = 8'b00010001;
        overlap_en = 1'b0;
        step(0, 0, 1, 4'b1010, 1, 0);
        void'(sb.pop_front());
        for (int i = 7; i >= 0; i--) begin
            step(b[i], 1, 0, 4'b0000, 0, e[i]);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL novl_y bit%0d got %b want %b", 8 - i, y, exp_y); else passed++;
        end
        checks++; if (match_cnt !== 8'd2) $display("FAIL novl_cnt got %0d want 2", match_cnt); else passed++;
    endtask

    task automatic test_valid_gaps();
        logic [3:0] b = 4'b1010;
        overlap_en = 1'b1;
        step(0, 0, 1, 4'b1010, 1, 0);
        void'(sb.pop_front());
        for (int i = 3; i >= 0; i--) begin
            step(b[i], 1, 0, 4'b0000, 0, i == 0);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL gap_y bit%0d got %b want %b", 4 - i, y, exp_y); else passed++;
            for (int g = 0; g < 3; g++) begin
                step(1'($urandom_range(0, 1)), 0, 0, 4'b0000, 0, 0);
                exp_y = sb.pop_front();
                checks++; if (y !== exp_y) $display("FAIL gap_idle_y bit%0d got %b want %b", 4 - i, y, exp_y); else passed++;
            end
        end
        checks++; if (match_cnt !== 8'd1) $display("FAIL gap_cnt got %0d want 1", match_cnt); else passed++;
    endtask

    task automatic test_cfg_load();
        logic [4:0] e = 5'b00011;
        overlap_en = 1'b1;
        step(0, 0, 1, 4'b1010, 1, 0);
        void'(sb.pop_front());
        step(1, 1, 0, 4'b0000, 0, 0);
        step(0, 1, 0, 4'b0000, 0, 0);
        step(0, 1, 1, 4'b0000, 0, 0);
        repeat (3) begin
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL cfg_pre_y got %b want %b", y, exp_y); else passed++;
        end
        for (int i = 4; i >= 0; i--) begin
            step(0, 1, 0, 4'b0000, 0, e[i]);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL cfg_zero_y bit%0d got %b want %b", 5 - i, y, exp_y); else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [11:0] b = 12'b101010101010, e = 12'b000101010101;
        overlap_en = 1'b1;
        step(0, 0, 1, 4'b1010, 1, 0);
        void'(sb.pop_front());
        for (int i = 11; i >= 0; i--) begin
            step(b[i], 1, 0, 4'b0000, 0, e[i]);
            exp_y = sb.pop_front();
            checks++; if (y2 !== exp_y) $display("FAIL sat_y bit%0d got %b want %b", 12 - i, y2, exp_y); else passed++;
        end
        checks++; if (match_cnt2 !== 2'd3 || cnt_sat2 !== 1'b1) $display("FAIL sat_cnt2 got %0d sat %b want 3 sat 1", match_cnt2, cnt_sat2); else passed++;
        checks++; if (match_cnt !== 8'd5 || cnt_sat !== 1'b0) $display("FAIL sat_cnt8 got %0d sat %b want 5 sat 0", match_cnt, cnt_sat); else passed++;
        step(1, 1, 0, 4'b0000, 0, 0);
        step(0, 1, 0, 4'b0000, 1, 1);
        void'(sb.pop_front());
        exp_y = sb.pop_front();
        checks++; if (y !== exp_y || y2 !== exp_y) $display("FAIL clr_hit_y got %b/%b want %b", y, y2, exp_y); else passed++;
        checks++; if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0) $display("FAIL clr_hit_cnt got %0d/%0d sat %b want 0/0 sat 0", match_cnt, match_cnt2, cnt_sat2); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] b = 7'b0110101, e = 7'b0001000;
        logic [4:0] b2 = 5'b01010, e2 = 5'b00001;
        overlap_en = 1'b0;
        step(0, 0, 1, 4'b0110, 1, 0);
        void'(sb.pop_front());
        for (int i = 6; i >= 0; i--) begin
            step(b[i], 1, 0, 4'b0000, 0, e[i]);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL rmid_pre_y bit%0d got %b want %b", 7 - i, y, exp_y); else passed++;
        end
        checks++; if (match_cnt !== 8'd1) $display("FAIL rmid_pre_cnt got %0d want 1", match_cnt); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if (y !== 1'b0 || match_cnt !== 8'd0) $display("FAIL rmid_async got y %b cnt %0d want 0 0", y, match_cnt); else passed++;
        din = 1'b0; din_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (y !== 1'b0 || match_cnt !== 8'd0) $display("FAIL rmid_hold got y %b cnt %0d want 0 0", y, match_cnt); else passed++;
        din_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 4; i >= 0; i--) begin
            step(b2[i], 1, 0, 4'b0000, 0, e2[i]);
            exp_y = sb.pop_front();
            checks++; if (y !== exp_y) $display("FAIL rmid_post_y bit%0d got %b want %b", 5 - i, y, exp_y); else passed++;
        end
        checks++; if (match_cnt !== 8'd1) $display("FAIL rmid_post_cnt got %0d want 1", match_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gaps();
        test_cfg_load();
        test_saturation();
        test_reset_mid();
        checks++; if (sb.size() != 0) $display("FAIL sb_left got %0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
